// File: rtl/bias_accum_out.sv
// Per-lane bias + multi-pass partial-sum accumulator with rounding, saturating requantisation to int8.
// Optional BIAS_ACCUM_RELU_EN macro clamps negative lane results to zero.
module bias_accum_out #(
  parameter int N_adder_tree = 16,
  parameter int N_PASS       = 6,
  parameter int SHIFT        = 8,
  parameter int ACC_W        = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_adder_tree*18-1:0]  bias_q,
  input  logic [N_adder_tree*18-1:0]  psum,
  input  logic                        psum_valid,
  output logic                        psum_ready,
  output logic [N_adder_tree*8-1:0]   out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4:0]                  pass_cnt
);

  localparam int DATA_W = 18;
  localparam int OUT_W  = 8;
  localparam logic [4:0] LAST = 5'(N_PASS - 1);
  localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Round half-up, arithmetic shift, saturate to int8; one guard bit keeps the rounding add from wrapping.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    logic [OUT_W-1:0] q;
    t = {s[ACC_W-1], s};
    t = (t + RND) >>> SHIFT;
    if (t > SAT_HI)      q = 8'h7f;
    else if (t < SAT_LO) q = 8'h80;
    else                 q = t[OUT_W-1:0];
`ifdef BIAS_ACCUM_RELU_EN
    if (q[OUT_W-1]) q = '0;
`endif
    return q;
  endfunction

  logic signed [ACC_W-1:0] acc_p1 [N_adder_tree];
  logic signed [ACC_W-1:0] sum_p0 [N_adder_tree];
  logic [N_adder_tree*OUT_W-1:0] res_p0;
  logic accept_p0;
  logic last_p0;

  assign psum_ready = !(out_valid && !out_ready);
  assign accept_p0  = psum_valid && psum_ready;
  assign last_p0    = accept_p0 && (pass_cnt == LAST);

  // Stage 0: combinational lane sums and their requantised form
  always_comb begin
    res_p0 = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      sum_p0[i] = ((pass_cnt == '0) ? sext(bias_q[DATA_W*i +: DATA_W]) : acc_p1[i])
                  + sext(psum[DATA_W*i +: DATA_W]);
      res_p0[OUT_W*i +: OUT_W] = requant(sum_p0[i]);
    end
  end

  // Stage 1: accumulator, pass counter and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < N_adder_tree; i++) acc_p1[i] <= '0;
    end else begin
      if (accept_p0) begin
        for (int i = 0; i < N_adder_tree; i++) acc_p1[i] <= sum_p0[i];
        pass_cnt <= last_p0 ? 5'd0 : pass_cnt + 5'd1;
      end
      if (last_p0) begin
        out_data  <= res_p0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bias_accum_out.md
BIAS_ACCUM_OUT -- requirements
Module: bias_accum_out

Interface
REQ-001 Parameter N_adder_tree, default 16, number of parallel output lanes.
REQ-002 Parameter N_PASS, default 6, number of partial-sum passes accumulated per output vector; legal range 1..32.
REQ-003 Parameter SHIFT, default 8, arithmetic right shift applied before requantisation; legal range 1..15.
REQ-004 Parameter ACC_W, default 24, signed accumulator width per lane.
REQ-005 clk  input  1  single clock; every register updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 bias_q  input  N_adder_tree*18  per-lane signed 18-bit bias; lane i is bits [18*(i+1)-1:18*i]; static for the duration of a layer.
REQ-008 psum  input  N_adder_tree*18  per-lane signed 18-bit adder-tree partial sum, same lane packing as bias_q.
REQ-009 psum_valid  input  1  psum is valid this cycle.
REQ-010 psum_ready  output  1  block accepts psum this cycle.
REQ-011 out_data  output  N_adder_tree*8  per-lane signed 8-bit result; lane i is bits [8*(i+1)-1:8*i].
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 pass_cnt  output  5  index of the next pass to be accepted (0..N_PASS-1).

Function
REQ-015 A psum beat is accepted when psum_valid and psum_ready are both high in the same cycle.
REQ-016 psum_ready = !(out_valid && !out_ready); this is combinational, with no other stall source.
REQ-017 On an accepted beat with pass_cnt==0: acc[i] <= sext(bias_q[i]) + sext(psum[i]) per lane.
REQ-018 On an accepted beat with pass_cnt>0: acc[i] <= acc[i] + sext(psum[i]).
REQ-019 The accumulator wraps as ACC_W two's complement; for N_PASS<=32, ACC_W=24 is sufficient and no overflow occurs.
REQ-020 pass_cnt increments on each accepted beat and wraps to 0 after N_PASS-1.
REQ-021 On the accepted beat with pass_cnt==N_PASS-1, the final sum s[i] (the acc update of REQ-017/018 applied to this beat) is requantised into out_data in the same clock edge, and out_valid is set; latency is 1 cycle from the final beat to out_valid.
REQ-022 Requantisation steps: r = (s + 2^(SHIFT-1)) >>> SHIFT (arithmetic), then saturate to [-128,127], then apply the REQ-031 clamp when enabled.
REQ-023 out_valid clears on out_valid && out_ready unless a new final beat is accepted in the same cycle; in that case out_valid stays high and out_data takes the new result.
REQ-024 out_data and out_valid are held stable while out_valid && !out_ready.
REQ-025 Non-final beats may be accepted while out_valid is high and out_ready is low only if psum_ready is high; per REQ-016 they are not, so the block stalls on all beats.
REQ-026 With N_PASS==1, every accepted beat is a final beat: out = requant(bias+psum).
REQ-027 psum_valid low holds acc and pass_cnt unchanged.

Reset
REQ-028 On rst: pass_cnt=0, out_valid=0, out_data=0, all acc lanes=0.
REQ-029 rst asserted mid-accumulation discards the partial sums; the first accepted beat after reset is pass 0.
REQ-030 rst dominates any simultaneous psum or out handshake.

Configuration
REQ-031 Macro BIAS_ACCUM_RELU_EN: when defined, a lane result r<0 is output as 0 (ReLU after saturation); when undefined, the signed saturated result is output unchanged.

Verification
REQ-032 All lanes bias=256, 6 beats psum=512, out_ready=1 -> sum 3328, out_data lane=8'd13, out_valid 1 cycle after the 6th beat.
REQ-033 Bias=0, 6 beats psum=6667 (sum 40002) -> saturate to 8'd127 on all lanes.
REQ-034 Sum=-1000 -> 8'hFC (-4) without BIAS_ACCUM_RELU_EN; 8'h00 with it.
REQ-035 out_ready=0 for 5 cycles after out_valid, psum_valid held high -> psum_ready=0, out_data stable, pass_cnt unchanged; accepting resumes the cycle out_ready=1.
REQ-036 rst pulse after 3 of 6 beats, then 6 fresh beats of 512 with bias 256 -> result 13, with no contribution from the pre-reset beats.
REQ-037 Back-to-back vectors with continuous valid/ready -> out_valid high every N_PASS cycles, and per-lane independence is checked with distinct lane biases.
